bcd_seg7_scanner: RTL

- Downstream consumer of the mod-10 BCD counter chain.
- Captures DIGITS packed BCD digits and time-multiplexes them onto one common 7-segment bus with per-digit anode enables.
- Provides a refresh prescaler, inter-digit blanking (anti-ghosting) and BCD-to-segment decode.
- Sits between the counter cascade and the board display pins.

---
 rtl/bcd_seg7_scanner.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/bcd_seg7_scanner.sv
// Multiplexed 7-segment scanner for packed BCD digits, with a refresh prescaler,
// inter-digit blanking and BCD decode. Define LEADING_ZERO_BLANK_EN to suppress leading zeros.
module bcd_seg7_scanner #(
    parameter int DIGITS         = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int BLANK_CYCLES   = 2,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [4*DIGITS-1:0]                         bcd_in,
    input  logic [DIGITS-1:0]                           dp_in,
    input  logic                                        load,
    output logic [6:0]                                  seg,
    output logic                                        dp,
    output logic [DIGITS-1:0]                           an,
    output logic [((DIGITS > 1) ? $clog2(DIGITS) : 1)-1:0] scan_idx
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNT_W = $clog2(REFRESH_DIV);

    localparam logic [6:0]        SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic              DP_OFF  = (SEG_ACTIVE_LOW != 0);
    localparam logic [DIGITS-1:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    logic [4*DIGITS-1:0] shadow_bcd_reg;
    logic [DIGITS-1:0]   shadow_dp_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic [IDX_W-1:0]    idx_reg;
    logic [6:0]          seg_reg, seg_next;
    logic                dp_reg, dp_next;
    logic [DIGITS-1:0]   an_reg, an_next;

    logic [3:0]          digit [DIGITS];
    logic [DIGITS-1:0]   lz_blank;
    logic [DIGITS-1:0]   an_onehot;
    logic                in_blank;
    logic                slot_end;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign digit[gi] = shadow_bcd_reg[4*gi +: 4];
        end
    endgenerate

`ifdef LEADING_ZERO_BLANK_EN
    // Walk down from the most significant digit; a digit stays dark while
    // everything above it (and itself) is zero and it carries no decimal point.
    always_comb begin
        logic upper_zero;
        upper_zero = 1'b1;
        lz_blank   = '0;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            upper_zero  = upper_zero && (digit[k] == 4'd0);
            lz_blank[k] = upper_zero && !shadow_dp_reg[k];
        end
    end
`else
    assign lz_blank = '0;
`endif

    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b0111111;
            4'd1:    s = 7'b0000110;
            4'd2:    s = 7'b1011011;
            4'd3:    s = 7'b1001111;
            4'd4:    s = 7'b1100110;
            4'd5:    s = 7'b1101101;
            4'd6:    s = 7'b1111101;
            4'd7:    s = 7'b0000111;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1101111;
            default: s = 7'b1000000;
        endcase
        return s;
    endfunction

    assign slot_end = (cnt_reg == CNT_W'(REFRESH_DIV - 1));
    assign in_blank = (BLANK_CYCLES > 0) && (int'(cnt_reg) < BLANK_CYCLES);

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_bcd_reg <= '0;
            shadow_dp_reg  <= '0;
        end else if (load) begin
            shadow_bcd_reg <= bcd_in;
            shadow_dp_reg  <= dp_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
            idx_reg <= '0;
        end else if (slot_end) begin
            cnt_reg <= '0;
            if (DIGITS == 1 || idx_reg == IDX_W'(DIGITS - 1)) begin
                idx_reg <= '0;
            end else begin
                idx_reg <= idx_reg + IDX_W'(1);
            end
        end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    always_comb begin
        an_onehot          = '0;
        an_onehot[idx_reg] = 1'b1;
    end

    always_comb begin
        seg_next = SEG_OFF;
        dp_next  = DP_OFF;
        an_next  = AN_OFF;
        if (!in_blank && !lz_blank[idx_reg]) begin
            seg_next = (SEG_ACTIVE_LOW != 0) ? ~decode(digit[idx_reg]) : decode(digit[idx_reg]);
            dp_next  = shadow_dp_reg[idx_reg] ^ DP_OFF;
            an_next  = an_onehot ^ AN_OFF;
        end
    end

    // Registered pins keep the anode/segment change glitch-free at slot boundaries.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_reg <= SEG_OFF;
            dp_reg  <= DP_OFF;
            an_reg  <= AN_OFF;
        end else begin
            seg_reg <= seg_next;
            dp_reg  <= dp_next;
            an_reg  <= an_next;
        end
    end

    assign seg      = seg_reg;
    assign dp       = dp_reg;
    assign an       = an_reg;
    assign scan_idx = idx_reg;

endmodule
